// File: rtl/branch_pred_defs.sv
`default_nettype none
// Shared definitions for the branch predictor: counter encodings and default geometry.
package branch_pred_defs;

  localparam int DEFAULT_IDX_W = 3;
  localparam int PC_W          = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Initial confidence for a freshly allocated entry.
  function automatic ctr_t alloc_state(input logic taken);
    return taken ? WEAK_T : WEAK_NT;
  endfunction

endpackage : branch_pred_defs
`default_nettype wire

// File: rtl/sat_counter_2bit.sv
`default_nettype none
// 2-bit saturating direction counter; load has priority over inc/dec.
module sat_counter_2bit
  import branch_pred_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  ctr_t load_val,
  output ctr_t count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= WEAK_NT;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      if (count != STRONG_T) count <= ctr_t'(count + 2'd1);
    end else if (dec) begin
      if (count != STRONG_NT) count <= ctr_t'(count - 2'd1);
    end
  end

endmodule : sat_counter_2bit
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
module branch_predictor
  import branch_pred_defs::*;
#(
  parameter int IDX_W = DEFAULT_IDX_W,
  parameter int TAG_W = 16 - IDX_W - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic        wen,
  input  logic [15:0] update_PC,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic        hit,
  output logic        predicted_taken,
  output logic [15:0] predicted_target
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [15:0]        targets [ENTRIES];
  ctr_t               ctrs    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_pc_lsb;

  assign lk_idx = PC_curr[IDX_W:1];
  assign lk_tag = PC_curr[15:IDX_W+1];
  assign up_idx = update_PC[IDX_W:1];
  assign up_tag = update_PC[15:IDX_W+1];
  assign unused_pc_lsb = ^{PC_curr[0], update_PC[0]};

  // Lookup reads the flops directly, so an update in flight is not visible yet.
  assign hit              = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign predicted_taken  = hit && ctrs[lk_idx][1];
  assign predicted_target = hit ? targets[lk_idx] : 16'h0000;

  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
      end
    end else if (wen) begin
      if (!up_hit) begin
        valid[up_idx]   <= 1'b1;
        tags[up_idx]    <= up_tag;
        targets[up_idx] <= actual_target;
      end else if (actual_taken) begin
        targets[up_idx] <= actual_target;
      end
    end
  end

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      logic sel;
      assign sel = wen && (up_idx == IDX_W'(i));

      sat_counter_2bit u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sel && up_hit && actual_taken),
        .dec      (sel && up_hit && !actual_taken),
        .load     (sel && !up_hit),
        .load_val (alloc_state(actual_taken)),
        .count    (ctrs[i])
      );
    end
  endgenerate

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] PC_curr;
  logic        wen;
  logic [15:0] update_PC;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        hit;
  logic        predicted_taken;
  logic [15:0] predicted_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_curr          (PC_curr),
    .wen              (wen),
    .update_PC        (update_PC),
    .actual_taken     (actual_taken),
    .actual_target    (actual_target),
    .hit              (hit),
    .predicted_taken  (predicted_taken),
    .predicted_target (predicted_target)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [15:0] pc,
                      input logic e_hit, input logic e_pt, input logic [15:0] e_tgt);
    PC_curr = pc;
    #1;
    check({tag, ".hit"}, {15'd0, hit}, {15'd0, e_hit});
    check({tag, ".pt"},  {15'd0, predicted_taken}, {15'd0, e_pt});
    check({tag, ".tgt"}, predicted_target, e_tgt);
  endtask

  task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    wen           = 1'b1;
    update_PC     = pc;
    actual_taken  = taken;
    actual_target = tgt;
    tick();
    wen = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wen = 1'b0;
    update_PC = '0;
    actual_taken = 1'b0;
    actual_target = '0;
    PC_curr = 16'h0010;
    #3;
    look("in_reset", 16'h0010, 1'b0, 1'b0, 16'h0000);
    #9 rst_n = 1'b1;
    tick();

    look("post_reset", 16'h0010, 1'b0, 1'b0, 16'h0000);

    // Allocate on taken -> WEAK_T.
    upd(16'h0010, 1'b1, 16'h0040);
    look("alloc_t", 16'h0010, 1'b1, 1'b1, 16'h0040);

    // Three taken: 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) upd(16'h0010, 1'b1, 16'h0040);
    look("sat_hi", 16'h0010, 1'b1, 1'b1, 16'h0040);

    // Not-taken: 11 -> 10, then 10 -> 01; target untouched.
    upd(16'h0010, 1'b0, 16'h0BAD);
    look("nt_1", 16'h0010, 1'b1, 1'b1, 16'h0040);
    upd(16'h0010, 1'b0, 16'h0BAD);
    look("nt_2", 16'h0010, 1'b1, 1'b0, 16'h0040);

    // Same-cycle lookup and update: counter 01, taken; old value visible first.
    PC_curr = 16'h0010;
    wen = 1'b1; update_PC = 16'h0010; actual_taken = 1'b1; actual_target = 16'h0040;
    #1;
    check("same_cyc.pt_before", {15'd0, predicted_taken}, 16'd0);
    tick();
    wen = 1'b0;
    look("same_cyc_after", 16'h0010, 1'b1, 1'b1, 16'h0040);

    // Low saturation: 10 -> 01 -> 00 -> 00, then taken -> 01, taken -> 10.
    for (int i = 0; i < 3; i++) upd(16'h0010, 1'b0, 16'h0000);
    look("sat_lo", 16'h0010, 1'b1, 1'b0, 16'h0040);
    upd(16'h0010, 1'b1, 16'h0080);
    look("lo_inc1", 16'h0010, 1'b1, 1'b0, 16'h0080);
    upd(16'h0010, 1'b1, 16'h0080);
    look("lo_inc2", 16'h0010, 1'b1, 1'b1, 16'h0080);

    // Alias: same index, different tag, not-taken replaces entry.
    upd(16'h0020, 1'b0, 16'h0099);
    look("alias_old", 16'h0010, 1'b0, 1'b0, 16'h0000);
    look("alias_new", 16'h0020, 1'b1, 1'b0, 16'h0099);

    // Different index; PC[0] ignored on both ports.
    upd(16'h0013, 1'b1, 16'h1234);
    look("idx1", 16'h0012, 1'b1, 1'b1, 16'h1234);
    look("idx0_kept", 16'h0021, 1'b1, 1'b0, 16'h0099);

    // Idle cycles hold contents.
    tick(); tick();
    look("hold", 16'h0012, 1'b1, 1'b1, 16'h1234);

    // Asynchronous reset mid-cycle with wen high discards the update.
    wen = 1'b1; update_PC = 16'h0030; actual_taken = 1'b1; actual_target = 16'h5555;
    PC_curr = 16'h0012;
    #2 rst_n = 1'b0;
    #1;
    check("async_clr.hit", {15'd0, hit}, 16'd0);
    check("async_clr.tgt", predicted_target, 16'h0000);
    @(posedge clk); @(posedge clk);
    #2 wen = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    look("rel_0030", 16'h0030, 1'b0, 1'b0, 16'h0000);
    look("rel_0020", 16'h0020, 1'b0, 1'b0, 16'h0000);
    look("rel_0012", 16'h0012, 1'b0, 1'b0, 16'h0000);

    upd(16'h0030, 1'b1, 16'h5555);
    look("post_rel_upd", 16'h0030, 1'b1, 1'b1, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
